conv1d_mac_engine: RTL

- Parametrised, pipelined successor to the 4-lane 8-bit CONV1D datapath. Adds configurable lane count and widths, signed or unsigned mode, optional saturation, and its own control FSM.
- Uses valid/ready handshakes on both the input stream and the result.
- Computes the dot product of a stored kernel vector with each input beat and accumulates over a programmed number of beats. Sits between the bus-interface FSM and the result register file.

---
 rtl/conv1d_mac_engine_if.sv | 30 +++
 rtl/conv1d_mac_engine.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/conv1d_mac_engine_if.sv
// Stream/result handshake bundle for conv1d_mac_engine.
// master = stimulus/consumer side, slave = engine side.
interface conv1d_mac_engine_if #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
);
  logic [LANES*DW-1:0] in_data;
  logic                ker_we;
  logic                start;
  logic [LEN_W-1:0]    len;
  logic                in_valid;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    result;
  logic                overflow;
  logic                busy;

  modport master (
    output in_data, ker_we, start, len, in_valid, out_ready,
    input  in_ready, out_valid, result, overflow, busy
  );

  modport slave (
    input  in_data, ker_we, start, len, in_valid, out_ready,
    output in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/conv1d_mac_engine.sv
// Pipelined multi-lane dot-product accumulator with its own control FSM.
// Beat accepted at edge t: products at t, tree sum at t+1, accumulate at t+2.
module conv1d_mac_engine #(
  parameter int LANES  = 4,
  parameter int DW     = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 16,
  parameter int SIGNED = 1,
  parameter int SAT    = 0
) (
  input logic clk,
  input logic rst,
  conv1d_mac_engine_if.slave bus
);

  localparam int   PAD    = $clog2(LANES);
  localparam int   TREE_W = 2*DW + PAD;
  localparam int   WIDE_W = ((ACC_W > TREE_W) ? ACC_W : TREE_W) + 2;
  localparam logic SG     = (SIGNED != 0);
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, state_n;
  logic [LEN_W-1:0]    remaining;
  logic [DW-1:0]       kernel  [LANES];
  logic [2*DW-1:0]     prod_n  [LANES];
  logic [2*DW-1:0]     s1_prod [LANES];
  logic                s1_valid;
  logic [TREE_W-1:0]   tree_n;
  logic [TREE_W-1:0]   s2_sum;
  logic                s2_valid;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_n;
  logic                ovf_n;
  logic                ovf_sticky;
  logic [WIDE_W-1:0]   acc_ext, tree_ext, sum_wide;
  logic                accept, start_ok, ker_load;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_n       = state;
    accept        = 1'b0;
    start_ok      = 1'b0;
    ker_load      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        ker_load = bus.ker_we;
        if (bus.start) begin
          start_ok = 1'b1;
          state_n  = (bus.len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        bus.in_ready = (remaining != '0);
        if (bus.in_valid && bus.in_ready) begin
          accept = 1'b1;
          if (remaining == LEN_W'(1)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid) state_n = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Lane products; operands widened first so the low 2*DW bits are exact.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      prod_n[i] = {{DW{SG & bus.in_data[i*DW+DW-1]}}, bus.in_data[i*DW +: DW]}
                * {{DW{SG & kernel[i][DW-1]}}, kernel[i]};
    end
  end

  // Adder tree over the registered products.
  always_comb begin
    tree_n = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      tree_n = tree_n + {{PAD{SG & s1_prod[i][2*DW-1]}}, s1_prod[i]};
    end
  end

  // Accumulate in a wider domain so overflow is exact even when ACC_W is
  // narrower than the tree sum; then wrap or clamp back to ACC_W.
  always_comb begin
    acc_ext  = {{(WIDE_W-ACC_W){SG & acc[ACC_W-1]}}, acc};
    tree_ext = {{(WIDE_W-TREE_W){SG & s2_sum[TREE_W-1]}}, s2_sum};
    sum_wide = acc_ext + tree_ext;
    if (SG) ovf_n = !((&sum_wide[WIDE_W-1:ACC_W-1]) || !(|sum_wide[WIDE_W-1:ACC_W-1]));
    else    ovf_n = |sum_wide[WIDE_W-1:ACC_W];
    acc_n = sum_wide[ACC_W-1:0];
    if (ovf_n && (SAT != 0)) begin
      if (!SG)                  acc_n = '1;
      else if (sum_wide[WIDE_W-1]) acc_n = SMIN;
      else                      acc_n = SMAX;
    end
  end

  // Kernel, beat counter, pipeline stages and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        kernel[i]  <= '0;
        s1_prod[i] <= '0;
      end
      remaining  <= '0;
      s1_valid   <= 1'b0;
      s2_sum     <= '0;
      s2_valid   <= 1'b0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (ker_load) begin
        for (int unsigned i = 0; i < LANES; i++) kernel[i] <= bus.in_data[i*DW +: DW];
      end
      if (start_ok)    remaining <= bus.len;
      else if (accept) remaining <= remaining - LEN_W'(1);
      s1_valid <= accept;
      if (accept) s1_prod <= prod_n;
      s2_valid <= s1_valid;
      if (s1_valid) s2_sum <= tree_n;
      if (start_ok) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end else if (s2_valid) begin
        acc <= acc_n;
        if (ovf_n) ovf_sticky <= 1'b1;
      end
    end
  end

  assign bus.result   = acc;
  assign bus.overflow = ovf_sticky;

endmodule
